// File: rtl/gamepad_poller_if.sv
// Bus bundle between gamepad_poller, the gamepad adapter (enables, Q) and CPU decode.
// master = poller side; slave = adapter/CPU side.
interface gamepad_poller_if;
   logic       _OErandom;
   logic       _OEpad1;
   logic       _OEpad2;
   logic [7:0] Q;
   logic       rand_req;
   logic       rand_ack;
   logic [7:0] rand_data;
   logic [7:0] pad1;
   logic [7:0] pad2;
   logic       pads_valid;
   logic       busy;
   logic       pad_irq;

   modport master (
      output _OErandom, _OEpad1, _OEpad2, rand_ack, rand_data,
             pad1, pad2, pads_valid, busy, pad_irq,
      input  Q, rand_req
   );

   modport slave (
      input  _OErandom, _OEpad1, _OEpad2, rand_ack, rand_data,
             pad1, pad2, pads_valid, busy, pad_irq,
      output Q, rand_req
   );
endinterface

// File: rtl/gamepad_poller.sv
// Shares the adapter Q bus between periodic pad scans and CPU random-byte reads.
// Optional change interrupt on pad commit: define GAMEPAD_POLLER_IRQ_EN.
module gamepad_poller #(
   parameter int SETTLE      = 2,
   parameter int POLL_PERIOD = 1000
) (
   input logic              clk,
   input logic              _mr,
   gamepad_poller_if.master bus
);
   localparam int TW = $clog2(POLL_PERIOD);
   localparam logic [TW-1:0] T_LAST   = TW'(POLL_PERIOD - 1);
   localparam logic [3:0]    CNT_LAST = 4'(SETTLE);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   localparam logic [1:0] SRC_RAND = 2'd0;
   localparam logic [1:0] SRC_PAD1 = 2'd1;
   localparam logic [1:0] SRC_PAD2 = 2'd2;

   logic [1:0]    state, src;
   logic [3:0]    cnt;
   logic [TW-1:0] tmr;
   logic          scan_pending, last_scan;
   logic [7:0]    shadow, rand_data_q, pad1_q, pad2_q;
   logic          oe_rand_n, oe_pad1_n, oe_pad2_n;
   logic          rand_ack_q, pads_valid_q;
   logic          wrap, pick_scan, done;

   assign wrap      = (tmr == T_LAST);
   assign done      = (state == S_DRIVE) && (cnt == CNT_LAST);
   // On a tie, the source not served last wins; last_scan resets low so scan wins first.
   assign pick_scan = scan_pending && (!bus.rand_req || !last_scan);

   always_ff @(posedge clk or negedge _mr) begin
      if (!_mr) begin
         state        <= S_IDLE;
         src          <= SRC_RAND;
         cnt          <= 4'd0;
         tmr          <= '0;
         scan_pending <= 1'b0;
         last_scan    <= 1'b0;
         shadow       <= 8'h00;
         rand_data_q  <= 8'h00;
         pad1_q       <= 8'h00;
         pad2_q       <= 8'h00;
         oe_rand_n    <= 1'b1;
         oe_pad1_n    <= 1'b1;
         oe_pad2_n    <= 1'b1;
         rand_ack_q   <= 1'b0;
         pads_valid_q <= 1'b0;
      end else begin
         rand_ack_q <= 1'b0;
         tmr        <= wrap ? '0 : tmr + 1'b1;
         // A wrap while already pending is absorbed; starting a scan below overrides it.
         if (wrap) scan_pending <= 1'b1;
         case (state)
            S_IDLE: begin
               if (pick_scan) begin
                  scan_pending <= 1'b0;
                  last_scan    <= 1'b1;
                  src          <= SRC_PAD1;
                  oe_pad1_n    <= 1'b0;
                  cnt          <= 4'd1;
                  state        <= S_DRIVE;
               end else if (bus.rand_req) begin
                  last_scan <= 1'b0;
                  src       <= SRC_RAND;
                  oe_rand_n <= 1'b0;
                  cnt       <= 4'd1;
                  state     <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               if (done) begin
                  oe_rand_n <= 1'b1;
                  oe_pad1_n <= 1'b1;
                  oe_pad2_n <= 1'b1;
                  state     <= S_GAP;
                  case (src)
                     SRC_RAND: begin
                        rand_data_q <= bus.Q;
                        rand_ack_q  <= 1'b1;
                     end
                     SRC_PAD1: shadow <= bus.Q;
                     default: begin
                        pad1_q       <= shadow;
                        pad2_q       <= bus.Q;
                        pads_valid_q <= 1'b1;
                     end
                  endcase
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_GAP: begin
               // PAD2 follows PAD1 directly so a scan is never split by a random read.
               if (src == SRC_PAD1) begin
                  src       <= SRC_PAD2;
                  oe_pad2_n <= 1'b0;
                  cnt       <= 4'd1;
                  state     <= S_DRIVE;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef GAMEPAD_POLLER_IRQ_EN
   logic pad_irq_q;

   // Committed pad registers double as the previous value (0x0000 after reset).
   always_ff @(posedge clk or negedge _mr) begin
      if (!_mr) pad_irq_q <= 1'b0;
      else      pad_irq_q <= done && (src == SRC_PAD2) && ({bus.Q, shadow} != {pad2_q, pad1_q});
   end

   assign bus.pad_irq = pad_irq_q;
`else
   assign bus.pad_irq = 1'b0;
`endif

   assign bus._OErandom  = oe_rand_n;
   assign bus._OEpad1    = oe_pad1_n;
   assign bus._OEpad2    = oe_pad2_n;
   assign bus.rand_ack   = rand_ack_q;
   assign bus.rand_data  = rand_data_q;
   assign bus.pad1       = pad1_q;
   assign bus.pad2       = pad2_q;
   assign bus.pads_valid = pads_valid_q;
   assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_gamepad_poller.sv
// Bench for gamepad_poller: cycle table, directed corner sequences and a random
// phase checked by a transaction-level bus monitor.
module tb_gamepad_poller;
   localparam int S = 2;
   localparam int P = 24;
`ifdef GAMEPAD_POLLER_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif

   logic clk = 1'b0;
   logic _mr = 1'b0;
   gamepad_poller_if bus();

   gamepad_poller #(.SETTLE(S), .POLL_PERIOD(P)) dut (
      .clk (clk),
      ._mr (_mr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Adapter model: whichever source is enabled drives Q.
   logic [7:0] v_rand, v_p1, v_p2;
   always_comb begin
      bus.Q = 8'hEE;
      if (!bus._OErandom)    bus.Q = v_rand;
      else if (!bus._OEpad1) bus.Q = v_p1;
      else if (!bus._OEpad2) bus.Q = v_p2;
   end

   // Monitor: reference model built from bus-level rules, sampled on the falling edge.
   int         cyc, pend_at, run, rise1_at, n_scans, n_rands;
   bit         pend;
   logic       prev_r, prev_1, prev_2;
   logic [7:0] lat_r, lat_1, lat_2, m_rdata, m_pad1, m_pad2;
   logic       m_valid;

   always @(negedge clk) begin
      int   lows;
      logic rise_r, rise_1, rise_2, exp_irq;
      if (!_mr) begin
         cyc = 0; pend = 0; pend_at = 0; run = 0; rise1_at = -10;
         n_scans = 0; n_rands = 0;
         prev_r = 1'b1; prev_1 = 1'b1; prev_2 = 1'b1;
         lat_r = 8'h00; lat_1 = 8'h00; lat_2 = 8'h00;
         m_rdata = 8'h00; m_pad1 = 8'h00; m_pad2 = 8'h00; m_valid = 1'b0;
      end else begin
         cyc++;
         if (cyc % P == 0) begin
            if (!pend) pend_at = cyc;
            pend = 1;
         end
         lows    = int'(!bus._OErandom) + int'(!bus._OEpad1) + int'(!bus._OEpad2);
         rise_r  = !prev_r && bus._OErandom;
         rise_1  = !prev_1 && bus._OEpad1;
         rise_2  = !prev_2 && bus._OEpad2;
         exp_irq = 1'b0;
         chk("one_enable_low", lows <= 1, 1);
         if (!bus._OErandom) lat_r = v_rand;
         if (!bus._OEpad1)   lat_1 = v_p1;
         if (!bus._OEpad2)   lat_2 = v_p2;
         if (prev_1 && !bus._OEpad1) begin
            chk("scan_had_pending", pend, 1);
            chk("scan_start_latency", (cyc - pend_at) <= S + 2, 1);
            pend = 0;
         end
         if (prev_2 && !bus._OEpad2) chk("scan_atomic", cyc == rise1_at + 1, 1);
         if (lows > 0) begin
            run++;
            chk("busy_in_drive", bus.busy, 1);
         end
         if (rise_r || rise_1 || rise_2) begin
            chk("settle_len", run, S);
            chk("gap_all_high", lows, 0);
            chk("busy_in_gap", bus.busy, 1);
            run = 0;
         end
         if (rise_r) begin m_rdata = lat_r; n_rands++; end
         if (rise_1) rise1_at = cyc;
         if (rise_2) begin
            exp_irq = IRQ && ({lat_2, lat_1} != {m_pad2, m_pad1});
            m_pad1 = lat_1; m_pad2 = lat_2; m_valid = 1'b1; n_scans++;
         end
         chk("rand_ack", bus.rand_ack, rise_r);
         chk("rand_data", bus.rand_data, m_rdata);
         chk("pad1", bus.pad1, m_pad1);
         chk("pad2", bus.pad2, m_pad2);
         chk("pads_valid", bus.pads_valid, m_valid);
         chk("pad_irq", bus.pad_irq, exp_irq);
         prev_r = bus._OErandom; prev_1 = bus._OEpad1; prev_2 = bus._OEpad2;
      end
   end

   task automatic do_reset();
      _mr = 1'b0;
      bus.rand_req = 1'b0;
      repeat (2) @(negedge clk);
      #2 _mr = 1'b1;
   endtask

   function automatic logic oe_of(input int which);
      case (which)
         0:       return bus._OErandom;
         1:       return bus._OEpad1;
         default: return bus._OEpad2;
      endcase
   endfunction

   task automatic wait_oe(input string nm, input int which, input logic lvl, input int lim,
                          output int n);
      n = 0;
      while (oe_of(which) !== lvl && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(nm, oe_of(which), lvl);
   endtask

   typedef struct {
      logic       req;
      logic [7:0] q;
      logic       e_oer;
      logic       e_ack;
      logic       e_busy;
      logic [7:0] e_data;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int n, k, wait_n, wr;
      logic exp_irq_seq[3];
      tbl[0]  = '{1'b1, 8'h7E, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[1]  = '{1'b1, 8'h7E, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[2]  = '{1'b1, 8'h7E, 1'b1, 1'b1, 1'b1, 8'h7E};
      tbl[3]  = '{1'b0, 8'h7E, 1'b1, 1'b0, 1'b0, 8'h7E};
      tbl[4]  = '{1'b0, 8'h7E, 1'b1, 1'b0, 1'b0, 8'h7E};
      tbl[5]  = '{1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 8'h7E};
      tbl[6]  = '{1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 8'h7E};
      tbl[7]  = '{1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 8'h81};
      tbl[8]  = '{1'b0, 8'h81, 1'b1, 1'b0, 1'b0, 8'h81};
      tbl[9]  = '{1'b1, 8'hC4, 1'b0, 1'b0, 1'b1, 8'h81};
      tbl[10] = '{1'b1, 8'hC4, 1'b0, 1'b0, 1'b1, 8'h81};
      tbl[11] = '{1'b1, 8'hC4, 1'b1, 1'b1, 1'b1, 8'hC4};
      tbl[12] = '{1'b0, 8'hC4, 1'b1, 1'b0, 1'b0, 8'hC4};

      bus.rand_req = 1'b0;
      v_rand = 8'h00; v_p1 = 8'h00; v_p2 = 8'h00;

      // Reset state, then idle until the first wrap starts a scan.
      do_reset();
      chk("rst_oer", bus._OErandom, 1);
      chk("rst_oe1", bus._OEpad1, 1);
      chk("rst_oe2", bus._OEpad2, 1);
      chk("rst_ack", bus.rand_ack, 0);
      chk("rst_valid", bus.pads_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_irq", bus.pad_irq, 0);
      chk("rst_data", bus.rand_data, 8'h00);
      chk("rst_pads", {bus.pad2, bus.pad1}, 16'h0000);
      v_p1 = 8'h5A; v_p2 = 8'hC3;
      wait_oe("first_scan_start", 1, 1'b0, P + 5, n);
      chk("first_scan_cycle", n, P + 1);
      k = 0;
      while (!bus.pads_valid && k < 4 * S + 8) begin
         chk("pads_held_before_commit", {bus.pad2, bus.pad1}, 16'h0000);
         @(negedge clk);
         k++;
      end
      chk("commit_cycle", k, 2 * S + 1);
      chk("commit_pad1", bus.pad1, 8'h5A);
      chk("commit_pad2", bus.pad2, 8'hC3);

      // Cycle table: three back-to-back random reads.
      do_reset();
      for (int i = 0; i < 13; i++) begin
         bus.rand_req = tbl[i].req;
         v_rand       = tbl[i].q;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("tbl%0d_oer", i), bus._OErandom, tbl[i].e_oer);
         chk($sformatf("tbl%0d_ack", i), bus.rand_ack, tbl[i].e_ack);
         chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].e_busy);
         chk($sformatf("tbl%0d_data", i), bus.rand_data, tbl[i].e_data);
      end

      // Scan and random read both pending: scan first, then the random slot.
      do_reset();
      v_rand = 8'h3D; v_p1 = 8'h11; v_p2 = 8'h22;
      repeat (P) @(negedge clk);
      bus.rand_req = 1'b1;
      @(negedge clk);
      k = 1;
      chk("tie_scan_first_p1", bus._OEpad1, 0);
      chk("tie_scan_first_r", bus._OErandom, 1);
      while (!bus.rand_ack && k < 6 * (S + 1)) begin
         @(negedge clk);
         k++;
      end
      chk("tie_rand_latency", k, 3 * (S + 1) + 1);
      chk("tie_scan_done", bus.pads_valid, 1);
      chk("tie_rand_data", bus.rand_data, 8'h3D);
      bus.rand_req = 1'b0;

      // Random phase: near-continuous requests and random adapter data.
      do_reset();
      wait_n = 0;
      for (int i = 0; i < 40 * P; i++) begin
         @(negedge clk);
         if (bus._OErandom && bus._OEpad1 && bus._OEpad2) begin
            v_rand = 8'($urandom);
            if ($urandom_range(1) == 1) begin
               v_p1 = 8'($urandom);
               v_p2 = 8'($urandom);
            end
         end
         if (bus.rand_req && bus.rand_ack) begin
            chk("rand_latency_bound", wait_n <= 3 * (S + 1), 1);
            bus.rand_req = 1'b0;
         end else if (bus.rand_req) begin
            wait_n++;
         end else if ($urandom_range(3) != 0) begin
            bus.rand_req = 1'b1;
            wait_n = 0;
         end
      end
      #1;
      wr = 40;
      chk("scans_not_starved", (n_scans >= wr - 1) && (n_scans <= wr), 1);
      chk("rands_not_starved", n_rands >= (40 * P) / (6 * (S + 1)), 1);

      // Change interrupt: same value twice, then pad2 changes.
      do_reset();
      v_p1 = 8'h22; v_p2 = 8'h00;
      exp_irq_seq[0] = IRQ; exp_irq_seq[1] = 1'b0; exp_irq_seq[2] = IRQ;
      for (int s = 0; s < 3; s++) begin
         if (s == 2) v_p2 = 8'h01;
         wait_oe($sformatf("irq_scan%0d_p2_low", s), 2, 1'b0, 2 * P + 10, n);
         wait_oe($sformatf("irq_scan%0d_p2_high", s), 2, 1'b1, 2 * S + 4, n);
         chk($sformatf("irq_scan%0d", s), bus.pad_irq, exp_irq_seq[s]);
      end

      // Master reset in the middle of a PAD2 drive releases the bus at once.
      do_reset();
      v_p1 = 8'h9A; v_p2 = 8'hB5;
      wait_oe("mr_p2_low", 2, 1'b0, 2 * P + 10, n);
      #2 _mr = 1'b0;
      #1;
      chk("mr_oer", bus._OErandom, 1);
      chk("mr_oe1", bus._OEpad1, 1);
      chk("mr_oe2", bus._OEpad2, 1);
      chk("mr_busy", bus.busy, 0);
      chk("mr_valid", bus.pads_valid, 0);
      chk("mr_pads", {bus.pad2, bus.pad1}, 16'h0000);
      chk("mr_data", bus.rand_data, 8'h00);
      chk("mr_ack_irq", {bus.rand_ack, bus.pad_irq}, 2'b00);
      @(negedge clk);
      #2 _mr = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
